i2s_rx: RTL and testbench

Receive-side I2S deserialiser for the sound card's ADC input path (ADC_DOUT). It shares the BCK/LRCK that the board's I2S transmitter drives toward the DAC and ADC, and samples the serial ADC data on BCK rising edges. It assembles MSB-first, MSB-aligned left/right words and presents each completed stereo pair on a valid/ack handshake to the sound core's capture logic. All logic runs in the single system clock domain; BCK and LRCK are treated as data inputs and oversampled.

---
 rtl/i2s_rx.sv | 139 +++++++++++++
 tb/tb_i2s_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S receive deserialiser: oversamples BCK/LRCK in the clk domain, frames MSB-first
// left/right words and publishes each stereo pair on a valid/ack handshake.
// Optional I2S_RX_SYNC_EN adds a two-flop synchroniser on sclk, lrclk and sdata.
module i2s_rx #(
  parameter int unsigned AUDIO_DW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                lrclk,
  input  logic                sdata,
  input  logic                out_ack,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                out_valid,
  output logic                overrun,
  input  logic                overrun_clr
);

  localparam int unsigned CW = $clog2(AUDIO_DW + 1);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;
  state_t state, state_nx;

  logic sclk_s, lrclk_s, sdata_s;

`ifdef I2S_RX_SYNC_EN
  logic [1:0] sclk_q, lrclk_q, sdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q  <= '1;
      lrclk_q <= '1;
      sdata_q <= '0;
    end else begin
      sclk_q  <= {sclk_q[0], sclk};
      lrclk_q <= {lrclk_q[0], lrclk};
      sdata_q <= {sdata_q[0], sdata};
    end
  end

  assign sclk_s  = sclk_q[1];
  assign lrclk_s = lrclk_q[1];
  assign sdata_s = sdata_q[1];
`else
  assign sclk_s  = sclk;
  assign lrclk_s = lrclk;
  assign sdata_s = sdata;
`endif

  logic                sclk_d;
  logic                lr_prev;
  logic                lr_seen;
  logic [AUDIO_DW-1:0] sh, sh_nx, word, left_hold;
  logic [CW-1:0]       cnt, cnt_nx;
  logic                rise, lr_fall, lr_rise;
  logic                commit_left, commit_pair, clear_word;

  // Word under assembly including the current rise's bit, and its MSB-aligned form.
  always_comb begin
    rise    = sclk_s & ~sclk_d;
    // lr_prev only means something once a rise has actually been observed since
    // reset; this keeps a reset mid-left-word from framing a truncated word.
    lr_fall = lr_seen & lr_prev & ~lrclk_s;
    lr_rise = lr_seen & ~lr_prev & lrclk_s;
    sh_nx   = sh;
    cnt_nx  = cnt;
    if (cnt < CW'(AUDIO_DW)) begin
      sh_nx  = {sh[AUDIO_DW-2:0], sdata_s};
      cnt_nx = cnt + 1'b1;
    end
    word = sh_nx << (CW'(AUDIO_DW) - cnt_nx);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    commit_left = 1'b0;
    commit_pair = 1'b0;
    if (rise) begin
      case (state)
        SYNC:  if (lr_fall) state_nx = LEFT;
        LEFT:  if (lr_rise) begin
                 commit_left = 1'b1;
                 state_nx    = RIGHT;
               end
        RIGHT: if (lr_fall) begin
                 commit_pair = 1'b1;
                 state_nx    = LEFT;
               end
        default: state_nx = SYNC;
      endcase
    end
    clear_word = (state == SYNC) | commit_left | commit_pair;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_d     <= 1'b1;
      lr_prev    <= 1'b1;
      lr_seen    <= 1'b0;
      sh         <= '0;
      cnt        <= '0;
      left_hold  <= '0;
      left_chan  <= '0;
      right_chan <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      if (rise) begin
        lr_prev <= lrclk_s;
        lr_seen <= 1'b1;
        if (clear_word) begin
          sh  <= '0;
          cnt <= '0;
        end else begin
          sh  <= sh_nx;
          cnt <= cnt_nx;
        end
      end
      if (commit_left) left_hold <= word;
      if (commit_pair) begin
        left_chan  <= left_hold;
        right_chan <= word;
        out_valid  <= 1'b1;
      end else if (out_ack) begin
        out_valid <= 1'b0;
      end
      if (commit_pair && out_valid && !out_ack) overrun <= 1'b1;
      else if (overrun_clr)                     overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: framing, word-length alignment, handshake, overrun and reset.
module tb_i2s_rx;

`ifdef I2S_RX_SYNC_EN
  localparam int unsigned SYNC_LAT = 2;
`else
  localparam int unsigned SYNC_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b1;
  logic        lrclk = 1'b1;
  logic        sdata = 1'b0;
  logic        out_ack = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [15:0] left_chan, right_chan;
  logic        out_valid, overrun;

  int n_cmp = 0;
  int n_err = 0;

  i2s_rx #(.AUDIO_DW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .out_ack    (out_ack),
    .left_chan  (left_chan),
    .right_chan (right_chan),
    .out_valid  (out_valid),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic idle(input int unsigned c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  // One BCK period: lrclk/sdata change with sclk falling, 2 clk low, 2 clk high.
  task automatic send_bit(input logic lr, input logic d, input bit ack);
    @(posedge clk); #1;
    sclk = 1'b0; lrclk = lr; sdata = d;
    @(posedge clk); @(posedge clk); #1;
    sclk = 1'b1;
    if (ack) begin
      repeat (SYNC_LAT) @(posedge clk);
      #1 out_ack = 1'b1;
      @(posedge clk); #1 out_ack = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  // Slot bits taken MSB-first from l/r[31:...]; the last bit of each slot rides the next lr level.
  task automatic send_frame(input int unsigned n, input logic [31:0] l, input logic [31:0] r,
                            input bit ack_last);
    for (int unsigned i = 0; i < n; i++) send_bit(i == n - 1, l[31-i], 1'b0);
    for (int unsigned i = 0; i < n; i++) send_bit(i != n - 1, r[31-i], ack_last && (i == n - 1));
    idle(6);
  endtask

  task automatic do_ack();
    @(posedge clk); #1 out_ack = 1'b1;
    @(posedge clk); #1 out_ack = 1'b0;
  endtask

  task automatic test_reset();
    idle(3);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (left_chan !== 16'h0) begin n_err++; $display("FAIL reset_left: got %h want 0000", left_chan); end
    n_cmp++; if (right_chan !== 16'h0) begin n_err++; $display("FAIL reset_right: got %h want 0000", right_chan); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic_frame();
    send_frame(16, 32'h0, 32'h0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sync_frame_valid: got %b want 0", out_valid); end
    send_frame(16, 32'h8001_0000, 32'h7FFE_0000, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_cmp++; if (left_chan !== 16'h8001) begin n_err++; $display("FAIL basic_left: got %h want 8001", left_chan); end
    n_cmp++; if (right_chan !== 16'h7FFE) begin n_err++; $display("FAIL basic_right: got %h want 7ffe", right_chan); end
    do_ack();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_ack_release: got %b want 0", out_valid); end
  endtask

  task automatic test_long_word();
    send_frame(32, 32'h1234_5600, 32'hABCD_EF00, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL long_valid: got %b want 1", out_valid); end
    n_cmp++; if (left_chan !== 16'h1234) begin n_err++; $display("FAIL long_left: got %h want 1234", left_chan); end
    n_cmp++; if (right_chan !== 16'hABCD) begin n_err++; $display("FAIL long_right: got %h want abcd", right_chan); end
    do_ack();
  endtask

  task automatic test_short_word();
    send_frame(8, 32'hA500_0000, 32'h5A00_0000, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL short_valid: got %b want 1", out_valid); end
    n_cmp++; if (left_chan !== 16'hA500) begin n_err++; $display("FAIL short_left: got %h want a500", left_chan); end
    n_cmp++; if (right_chan !== 16'h5A00) begin n_err++; $display("FAIL short_right: got %h want 5a00", right_chan); end
    do_ack();
  endtask

  task automatic test_overrun();
    send_frame(16, 32'h1111_0000, 32'h2222_0000, 1'b0);
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first_flag: got %b want 0", overrun); end
    n_cmp++; if (left_chan !== 16'h1111) begin n_err++; $display("FAIL ovr_first_left: got %h want 1111", left_chan); end
    send_frame(16, 32'h3333_0000, 32'h4444_0000, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", out_valid); end
    n_cmp++; if (left_chan !== 16'h3333) begin n_err++; $display("FAIL ovr_left: got %h want 3333", left_chan); end
    n_cmp++; if (right_chan !== 16'h4444) begin n_err++; $display("FAIL ovr_right: got %h want 4444", right_chan); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clr: got %b want 0", overrun); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovr_clr_valid: got %b want 1", out_valid); end
    do_ack();
  endtask

  task automatic test_ack_commit();
    send_frame(16, 32'h0F0F_0000, 32'hF0F0_0000, 1'b0);
    send_frame(16, 32'h1357_0000, 32'h2468_0000, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ackc_valid: got %b want 1", out_valid); end
    n_cmp++; if (left_chan !== 16'h1357) begin n_err++; $display("FAIL ackc_left: got %h want 1357", left_chan); end
    n_cmp++; if (right_chan !== 16'h2468) begin n_err++; $display("FAIL ackc_right: got %h want 2468", right_chan); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ackc_overrun: got %b want 0", overrun); end
    do_ack();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ackc_release: got %b want 0", out_valid); end
  endtask

  task automatic test_ack_idle();
    do_ack();
    idle(2);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ackidle_valid: got %b want 0", out_valid); end
    n_cmp++; if (left_chan !== 16'h1357) begin n_err++; $display("FAIL ackidle_left: got %h want 1357", left_chan); end
  endtask

  task automatic test_startup_reset();
    @(posedge clk); #1 reset = 1'b1; sclk = 1'b1; lrclk = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    n_cmp++; if (left_chan !== 16'h0) begin n_err++; $display("FAIL rst2_left: got %h want 0000", left_chan); end
    // Join mid right-word, then frame into a left word that reset cuts in half.
    for (int unsigned i = 0; i < 7; i++) send_bit(1'b1, i[0], 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 8; i++) send_bit(1'b0, 1'b1, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst2_valid_after_pulse: got %b want 0", out_valid); end
    for (int unsigned i = 0; i < 7; i++) send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 15; i++) send_bit(1'b1, i[0], 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    idle(6);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst2_partial_frame_valid: got %b want 0", out_valid); end
    send_frame(16, 32'hCAFE_0000, 32'hBEEF_0000, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst2_valid: got %b want 1", out_valid); end
    n_cmp++; if (left_chan !== 16'hCAFE) begin n_err++; $display("FAIL rst2_left_frame: got %h want cafe", left_chan); end
    n_cmp++; if (right_chan !== 16'hBEEF) begin n_err++; $display("FAIL rst2_right_frame: got %h want beef", right_chan); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst2_overrun: got %b want 0", overrun); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_long_word();
    test_short_word();
    test_overrun();
    test_ack_commit();
    test_ack_idle();
    test_startup_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
